// File: rtl/dbg_gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbg_gpio_pkg
// Description : Shared types and defaults for the debug GPIO output block.
// Revision    : 1.0 - initial release
// ============================================================================
package dbg_gpio_pkg;

    localparam int DEFAULT_CH_NUM  = 4;
    localparam int DEFAULT_PULSE_W = 8;
    localparam int DEFAULT_CNT_W   = 16;

    typedef enum logic [1:0] {
        DBG_OFF    = 2'd0,
        DBG_TOGGLE = 2'd1,
        DBG_PULSE  = 2'd2,
        DBG_LEVEL  = 2'd3
    } dbg_mode_t;

    // Width of the counter read select; a single-channel build still needs one bit.
    function automatic int sel_width(input int ch_num);
        return (ch_num > 1) ? $clog2(ch_num) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dbg_gpio_out_if.sv
`default_nettype none
// ============================================================================
// Module      : dbg_gpio_out_if
// Description : Control/status bundle between an event source / config
//               manager (master) and the debug GPIO generator (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface dbg_gpio_out_if
    import dbg_gpio_pkg::*;
#(
    parameter int CH_NUM  = DEFAULT_CH_NUM,
    parameter int PULSE_W = DEFAULT_PULSE_W,
    parameter int CNT_W   = DEFAULT_CNT_W,
    parameter int SEL_W   = sel_width(CH_NUM)
);
    logic [CH_NUM-1:0]   evt;
    logic [2*CH_NUM-1:0] mode;
    logic [PULSE_W-1:0]  pulse_len;
    logic [SEL_W-1:0]    cnt_sel;
    logic [CH_NUM-1:0]   cnt_clr;
    logic [CNT_W-1:0]    cnt_out;
    logic [CH_NUM-1:0]   gpio_out;

    modport master (
        output evt, mode, pulse_len, cnt_sel, cnt_clr,
        input  cnt_out, gpio_out
    );

    modport slave (
        input  evt, mode, pulse_len, cnt_sel, cnt_clr,
        output cnt_out, gpio_out
    );

endinterface
`default_nettype wire

// File: rtl/dbg_gpio_ch.sv
`default_nettype none
// ============================================================================
// Module      : dbg_gpio_ch
// Description : One debug channel: two-stage event sampler with rising-edge
//               detect, off/toggle/pulse/level output modes, pulse-stretch
//               counter and a saturating event counter.
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_gpio_ch
    import dbg_gpio_pkg::*;
#(
    parameter int PULSE_W = DEFAULT_PULSE_W,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               evt,
    input  wire dbg_mode_t          mode,
    input  wire logic [PULSE_W-1:0] pulse_len,
    input  wire logic               cnt_clr,
    output logic                    gpio,
    output logic [CNT_W-1:0]        cnt
);

    logic               r_ev_q;
    logic               r_ev_qq;
    logic [PULSE_W-1:0] r_pcnt;
    logic               r_gpio;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_rise;
    logic [PULSE_W-1:0] w_len;

    assign w_rise = r_ev_q & ~r_ev_qq;
    // A zero length would give no visible pulse, so it is stretched to one cycle.
    assign w_len  = (pulse_len == '0) ? PULSE_W'(1) : pulse_len;

    // Event sampler keeps running through reset so a level already high at
    // release is not mistaken for a fresh edge.
    always_ff @(posedge clk) begin
        r_ev_q  <= evt;
        r_ev_qq <= r_ev_q;
    end

    // Output and pulse-stretch state per selected mode; any mode other than
    // pulse discards a pulse in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gpio <= 1'b0;
            r_pcnt <= '0;
        end else begin
            case (mode)
                DBG_OFF: begin
                    r_gpio <= 1'b0;
                    r_pcnt <= '0;
                end
                DBG_TOGGLE: begin
                    if (w_rise) begin
                        r_gpio <= ~r_gpio;
                    end
                    r_pcnt <= '0;
                end
                DBG_PULSE: begin
                    if (w_rise) begin
                        r_pcnt <= w_len;
                        r_gpio <= 1'b1;
                    end else if (r_pcnt > PULSE_W'(1)) begin
                        r_pcnt <= r_pcnt - PULSE_W'(1);
                        r_gpio <= 1'b1;
                    end else begin
                        r_pcnt <= '0;
                        r_gpio <= 1'b0;
                    end
                end
                DBG_LEVEL: begin
                    r_gpio <= r_ev_q;
                    r_pcnt <= '0;
                end
                default: begin
                    r_gpio <= 1'b0;
                    r_pcnt <= '0;
                end
            endcase
        end
    end

    // Saturating edge counter; a clear on the same cycle as an edge wins.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            r_cnt <= '0;
        end else if (w_rise && !(&r_cnt)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign gpio = r_gpio;
    assign cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/dbg_gpio_out.sv
`default_nettype none
// ============================================================================
// Module      : dbg_gpio_out
// Description : CH_NUM-channel debug GPIO generator with per-channel mode
//               select and a registered event-counter read port.
// Revision    : 1.0 - initial release
// ============================================================================
module dbg_gpio_out
    import dbg_gpio_pkg::*;
#(
    parameter int CH_NUM  = DEFAULT_CH_NUM,
    parameter int PULSE_W = DEFAULT_PULSE_W,
    parameter int CNT_W   = DEFAULT_CNT_W
) (
    input  wire logic     clk,
    input  wire logic     rst,
    dbg_gpio_out_if.slave bus
);

    localparam int SEL_W = sel_width(CH_NUM);

    logic [CH_NUM-1:0] w_gpio;
    logic [CNT_W-1:0]  w_cnt [CH_NUM];
    logic [CNT_W-1:0]  w_sel_cnt;
    logic [CNT_W-1:0]  r_cnt_out;

    for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
        dbg_gpio_ch #(
            .PULSE_W (PULSE_W),
            .CNT_W   (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .evt       (bus.evt[gi]),
            .mode      (dbg_mode_t'(bus.mode[2*gi +: 2])),
            .pulse_len (bus.pulse_len),
            .cnt_clr   (bus.cnt_clr[gi]),
            .gpio      (w_gpio[gi]),
            .cnt       (w_cnt[gi])
        );
    end

    // Counter read mux; a select beyond the last channel reads as zero.
    always_comb begin
        w_sel_cnt = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (bus.cnt_sel == SEL_W'(i)) begin
                w_sel_cnt = w_cnt[i];
            end
        end
    end

    // Register the selected counter for the config read path.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_out <= '0;
        end else begin
            r_cnt_out <= w_sel_cnt;
        end
    end

    assign bus.gpio_out = w_gpio;
    assign bus.cnt_out  = r_cnt_out;

endmodule
`default_nettype wire
